// File: rtl/reg_file_param_pkg.sv
// rtl/reg_file_param_pkg.sv - shared defaults and address-width helpers for the register file
package reg_file_param_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 32;
    localparam int DEF_NRD   = 2;

    // A DEPTH of 1 still needs a one-bit address bus to keep port widths legal.
    function automatic int addr_width(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    function automatic bit is_pow2(input int value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/reg_file_param_mux_nto1.sv
// rtl/reg_file_param_mux_nto1.sv - N-to-1 WIDTH-bit combinational selector over a flattened bus
//
// Ports:
//   din  - N*WIDTH bits, entry i in bits [i*WIDTH +: WIDTH]
//   sel  - addr_width(N) bits, entry select
//   dout - WIDTH bits, selected entry
module mux_nto1
    import reg_file_param_pkg::*;
#(
    parameter int N     = DEF_DEPTH,
    parameter int WIDTH = DEF_WIDTH,
    localparam int AW   = addr_width(N)
) (
    input  logic [N*WIDTH-1:0] din,
    input  logic [AW-1:0]      sel,
    output logic [WIDTH-1:0]   dout
);

    always_comb begin
        dout = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == AW'(i)) begin
                dout = din[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - multi-read-port register file with optional zero register, bypass and registered reads
//
// Ports:
//   clk   - clock, all state changes on the rising edge
//   rst   - asynchronous active-high reset, clears every register
//   we    - write enable
//   waddr - AW-bit write address
//   wdata - WIDTH-bit write data
//   raddr - NRD*AW bits, read port k address in [k*AW +: AW]
//   rdata - NRD*WIDTH bits, read port k data in [k*WIDTH +: WIDTH]
module reg_file_param
    import reg_file_param_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NRD      = DEF_NRD,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int REG_RD   = 0,
    localparam int AW      = addr_width(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [NRD*AW-1:0]  raddr,
    output logic [NRD*WIDTH-1:0] rdata
);

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("reg_file_param: DEPTH=%0d must be a power of two >= 2", DEPTH);
    end
    if (NRD < 1 || NRD > 4) begin : g_bad_nrd
        $error("reg_file_param: NRD=%0d must be within 1..4", NRD);
    end
    if (REG_RD != 0 && REG_RD != 1) begin : g_bad_reg_rd
        $error("reg_file_param: REG_RD=%0d must be 0 or 1", REG_RD);
    end

    logic [WIDTH-1:0]       mem [DEPTH];
    logic [DEPTH*WIDTH-1:0] mem_flat;
    logic                   wr_en;

    // A write to the hard-wired zero register is dropped entirely, so it never
    // reaches storage nor the bypass/forwarding paths.
    assign wr_en = we && !((ZERO_REG != 0) && (waddr == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[waddr] <= wdata;
        end
    end

    // Slot 0 is forced to zero here so every read port sees the zero register
    // without a per-port address compare.
    always_comb begin
        mem_flat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!((ZERO_REG != 0) && (i == 0))) begin
                mem_flat[i*WIDTH +: WIDTH] = mem[i];
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_port
        logic [AW-1:0]    ra;
        logic [WIDTH-1:0] mux_q;
        logic             hit;

        assign ra  = raddr[k*AW +: AW];
        assign hit = wr_en && (waddr == ra);

        mux_nto1 #(
            .N     (DEPTH),
            .WIDTH (WIDTH)
        ) u_mux (
            .din  (mem_flat),
            .sel  (ra),
            .dout (mux_q)
        );

        if (REG_RD != 0) begin : g_reg
            logic [WIDTH-1:0] rd_q;

            // Capture the post-edge contents: a write landing on this edge at
            // the same address is taken from wdata rather than the old array.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_q <= '0;
                end else begin
                    rd_q <= hit ? wdata : mux_q;
                end
            end

            assign rdata[k*WIDTH +: WIDTH] = rd_q;
        end else begin : g_comb
            // Reset blanks the port outright so a pending write is never forwarded.
            assign rdata[k*WIDTH +: WIDTH] = rst ? '0 :
                                             ((BYPASS != 0) && hit) ? wdata : mux_q;
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
// tb/tb_reg_file_param.sv - directed self-checking bench for reg_file_param
module tb_reg_file_param;

    logic        clk = 1'b0;
    logic        rst;

    // Shared stimulus for the 32x32 instances
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [9:0]  raddr;
    logic [63:0] rd_dflt;
    logic [63:0] rd_nobyp;
    logic [63:0] rd_nz;

    // Registered-read instance: WIDTH=16, DEPTH=8, NRD=3
    logic        r_we;
    logic [2:0]  r_waddr;
    logic [15:0] r_wdata;
    logic [8:0]  r_raddr;
    logic [47:0] r_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_file_param u_dflt (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rd_dflt)
    );

    reg_file_param #(.BYPASS(0)) u_nobyp (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rd_nobyp)
    );

    reg_file_param #(.ZERO_REG(0)) u_nz (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rd_nz)
    );

    reg_file_param #(.WIDTH(16), .DEPTH(8), .NRD(3), .REG_RD(1)) u_reg (
        .clk(clk), .rst(rst), .we(r_we), .waddr(r_waddr), .wdata(r_wdata),
        .raddr(r_raddr), .rdata(r_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        we = 1'b1; waddr = 5'd7; wdata = 32'hAAAA_AAAA; raddr = {5'd7, 5'd7};
        r_we = 1'b0; r_waddr = '0; r_wdata = '0; r_raddr = '0;

        // Writes during reset are ignored and never forwarded
        tick();
        check("rst_nobypass_dflt", rd_dflt[31:0], 32'h0);
        check("rst_nobypass_nz", rd_nz[31:0], 32'h0);
        check("rst_reg_rd", {16'h0, r_rdata[15:0]}, 32'h0);

        rst = 1'b0;
        we  = 1'b0;

        // Every address reads zero after reset, on both ports
        for (int i = 0; i < 32; i++) begin
            raddr = {5'(31 - i), 5'(i)};
            #1;
            check("reset_rd0", rd_dflt[31:0], 32'h0);
            check("reset_rd1", rd_dflt[63:32], 32'h0);
        end

        // Write then read on both ports
        tick();
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
        tick();
        we = 1'b0; raddr = {5'd5, 5'd5};
        #1;
        check("wr5_port0", rd_dflt[31:0], 32'hDEAD_BEEF);
        check("wr5_port1", rd_dflt[63:32], 32'hDEAD_BEEF);
        check("wr5_nobyp", rd_nobyp[31:0], 32'hDEAD_BEEF);

        // Same-cycle bypass vs. no bypass
        we = 1'b1; waddr = 5'd7; wdata = 32'h1234_5678; raddr = {5'd5, 5'd7};
        #1;
        check("bypass_on", rd_dflt[31:0], 32'h1234_5678);
        check("bypass_off_pre", rd_nobyp[31:0], 32'h0);
        check("bypass_other_port", rd_dflt[63:32], 32'hDEAD_BEEF);
        tick();
        we = 1'b0;
        #1;
        check("bypass_off_post", rd_nobyp[31:0], 32'h1234_5678);
        check("port_indep0", rd_dflt[31:0], 32'h1234_5678);
        check("port_indep1", rd_dflt[63:32], 32'hDEAD_BEEF);

        // Zero register ignores writes; ZERO_REG=0 keeps them
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; raddr = {5'd0, 5'd0};
        #1;
        check("zero_same", rd_dflt[31:0], 32'h0);
        check("zero_same_nobyp", rd_nobyp[31:0], 32'h0);
        check("nz_bypass", rd_nz[31:0], 32'hFFFF_FFFF);
        tick();
        we = 1'b0;
        #1;
        check("zero_next", rd_dflt[31:0], 32'h0);
        check("nz_stored", rd_nz[31:0], 32'hFFFF_FFFF);

        // Back-to-back writes to one address keep the last value
        we = 1'b1; waddr = 5'd10; wdata = 32'h0000_1111;
        tick();
        wdata = 32'h0000_2222;
        tick();
        we = 1'b0; raddr = {5'd10, 5'd31};
        #1;
        check("b2b_last", rd_dflt[63:32], 32'h0000_2222);
        check("top_addr_zero", rd_dflt[31:0], 32'h0);

        // Registered reads: write 0xA5A5 to 3 while port 2 watches address 3
        r_we = 1'b1; r_waddr = 3'd3; r_wdata = 16'hA5A5; r_raddr = {3'd3, 3'd3, 3'd0};
        #1;
        check("regrd_pre", {16'h0, r_rdata[47:32]}, 32'h0);
        tick();
        r_we = 1'b0;
        #1;
        check("regrd_post2", {16'h0, r_rdata[47:32]}, 32'h0000_A5A5);
        check("regrd_post1", {16'h0, r_rdata[31:16]}, 32'h0000_A5A5);
        check("regrd_post0", {16'h0, r_rdata[15:0]}, 32'h0);
        r_raddr = {3'd0, 3'd3, 3'd3};
        #1;
        check("regrd_latency", {16'h0, r_rdata[15:0]}, 32'h0);
        tick();
        check("regrd_latency_done", {16'h0, r_rdata[15:0]}, 32'h0000_A5A5);
        check("regrd_zero_port", {16'h0, r_rdata[47:32]}, 32'h0);
        r_we = 1'b1; r_waddr = 3'd0; r_wdata = 16'hFFFF;
        tick();
        r_we = 1'b0;
        check("regrd_zero_wr", {16'h0, r_rdata[47:32]}, 32'h0);
        r_raddr = {3'd3, 3'd3, 3'd3};
        tick();

        // Asynchronous reset between edges clears storage immediately
        we = 1'b1; waddr = 5'd9; wdata = 32'h0000_0055;
        tick();
        we = 1'b0; raddr = {5'd5, 5'd9};
        #1;
        check("wr9", rd_dflt[31:0], 32'h0000_0055);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst9", rd_dflt[31:0], 32'h0);
        check("async_rst5", rd_dflt[63:32], 32'h0);
        check("async_rst_reg", {16'h0, r_rdata[47:32]}, 32'h0);

        // Write coinciding with reset loses
        we = 1'b1; waddr = 5'd9; wdata = 32'h0000_0077;
        tick();
        check("rst_wins", rd_dflt[31:0], 32'h0);
        check("rst_wins_nobyp", rd_nobyp[31:0], 32'h0);

        // First edge after release writes normally
        rst = 1'b0; wdata = 32'h0000_0099;
        #1;
        check("release_pre", rd_nobyp[31:0], 32'h0);
        tick();
        we = 1'b0;
        #1;
        check("release_post", rd_dflt[31:0], 32'h0000_0099);
        check("release_post_nobyp", rd_nobyp[31:0], 32'h0000_0099);
        check("release_5_cleared", rd_dflt[63:32], 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
